// File: rtl/spin_judge.sv
// spin_judge: three-reel slot judge. Tracks reel motion, evaluates the payline and keeps the credit balance.
// Optional feature: define JACKPOT_STREAK_EN to pay TRIPLE_PAY*4 and raise jackpot on a symbol-3 triple.
module spin_judge #(
  parameter logic [7:0] CREDIT_INIT    = 8'd20,
  parameter logic [7:0] SPIN_COST      = 8'd1,
  parameter logic [7:0] PAIR_PAY       = 8'd2,
  parameter logic [7:0] TRIPLE_PAY     = 8'd10,
  parameter logic [7:0] PAYLINE_OFFSET = 8'd30,
  parameter logic [3:0] SETTLE_CYCLES  = 4'd4,
  parameter logic [4:0] MOVE_TIMEOUT   = 5'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] a_v_count,
  input  logic [9:0] b_v_count,
  input  logic [9:0] c_v_count,
  input  logic [2:0] reel_moving,
  output logic       spin_accept,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] symbol_a,
  output logic [1:0] symbol_b,
  output logic [1:0] symbol_c,
  output logic [1:0] win_code,
  output logic [7:0] credits,
  output logic       jackpot
);

  typedef enum logic [2:0] {IDLE, WAIT_MOVE, SPIN, SETTLE, EVAL} state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic [4:0] move_cnt;
  logic       do_accept, do_refund, do_eval;
  logic [1:0] sym_a_ev, sym_b_ev, sym_c_ev, win_ev;
  logic [7:0] payout;

  // Row on the payline folded into 0..239, then split into four 60-row bands.
  function automatic logic [1:0] reel_symbol(input logic [9:0] v_count);
    logic [8:0] v_adj;
    logic [8:0] row;
    v_adj = (v_count >= 10'd240) ? 9'(v_count - 10'd240) : v_count[8:0];
    row   = v_adj + {1'b0, PAYLINE_OFFSET};
    if (row >= 9'd480)      row = row - 9'd480;
    else if (row >= 9'd240) row = row - 9'd240;
    if (row < 9'd60)       return 2'd0;
    else if (row < 9'd120) return 2'd1;
    else if (row < 9'd180) return 2'd2;
    else                   return 2'd3;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_comb begin
    state_nxt = state;
    do_accept = 1'b0;
    do_refund = 1'b0;
    do_eval   = 1'b0;
    case (state)
      IDLE: if (start && (credits >= SPIN_COST)) begin
        state_nxt = WAIT_MOVE;
        do_accept = 1'b1;
      end
      WAIT_MOVE: begin
        if (reel_moving != 3'b000) state_nxt = SPIN;
        else if (move_cnt >= MOVE_TIMEOUT - 5'd1) begin
          state_nxt = IDLE;
          do_refund = 1'b1;
        end
      end
      SPIN: if (reel_moving == 3'b000) state_nxt = SETTLE;
      // The stop cycle seen in SPIN counts toward the settle window.
      SETTLE: begin
        if (reel_moving != 3'b000) state_nxt = SPIN;
        else if (settle_cnt + 4'd1 >= SETTLE_CYCLES - 4'd1) state_nxt = EVAL;
      end
      EVAL: begin
        state_nxt = IDLE;
        do_eval   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef JACKPOT_STREAK_EN
  logic       jackpot_hit;
  logic [9:0] jackpot_pay;
  assign jackpot_pay = {TRIPLE_PAY, 2'b00};
`endif

  always_comb begin
    sym_a_ev = reel_symbol(a_v_count);
    sym_b_ev = reel_symbol(b_v_count);
    sym_c_ev = reel_symbol(c_v_count);
    win_ev   = 2'd0;
    if ((sym_a_ev == sym_b_ev) && (sym_b_ev == sym_c_ev)) win_ev = 2'd2;
    else if ((sym_a_ev == sym_b_ev) || (sym_b_ev == sym_c_ev) || (sym_a_ev == sym_c_ev)) win_ev = 2'd1;
    case (win_ev)
      2'd2:    payout = TRIPLE_PAY;
      2'd1:    payout = PAIR_PAY;
      default: payout = 8'd0;
    endcase
`ifdef JACKPOT_STREAK_EN
    jackpot_hit = (win_ev == 2'd2) && (sym_a_ev == 2'd3);
    if (jackpot_hit) payout = (|jackpot_pay[9:8]) ? 8'hFF : jackpot_pay[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      move_cnt     <= 5'd0;
      spin_accept  <= 1'b0;
      result_valid <= 1'b0;
      credits      <= CREDIT_INIT;
      win_code     <= 2'd0;
      symbol_a     <= 2'd0;
      symbol_b     <= 2'd0;
      symbol_c     <= 2'd0;
    end else begin
      state        <= state_nxt;
      spin_accept  <= do_accept;
      result_valid <= do_eval;
      move_cnt     <= (state == WAIT_MOVE && reel_moving == 3'b000) ? move_cnt + 5'd1 : 5'd0;
      settle_cnt   <= (state == SETTLE && reel_moving == 3'b000) ? settle_cnt + 4'd1 : 4'd0;
      if (do_accept)      credits <= credits - SPIN_COST;
      else if (do_refund) credits <= sat_add(credits, SPIN_COST);
      else if (do_eval)   credits <= sat_add(credits, payout);
      if (do_accept)    win_code <= 2'd0;
      else if (do_eval) win_code <= win_ev;
      if (do_eval) begin
        symbol_a <= sym_a_ev;
        symbol_b <= sym_b_ev;
        symbol_c <= sym_c_ev;
      end
    end
  end

`ifdef JACKPOT_STREAK_EN
  always_ff @(posedge clk) begin
    if (rst)            jackpot <= 1'b0;
    else if (do_accept) jackpot <= 1'b0;
    else if (do_eval)   jackpot <= jackpot_hit;
  end
`else
  assign jackpot = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: doc/spin_judge.md
SPIN_JUDGE -- requirements
Module: spin_judge

Interface
REQ-001 SHALL have parameters: CREDIT_INIT, 8'd20, credits after reset; SPIN_COST, 8'd1, credits charged per spin; PAIR_PAY, 8'd2, payout for exactly two equal symbols; TRIPLE_PAY, 8'd10, payout for three equal symbols; PAYLINE_OFFSET, 8'd30, row offset of the payline; SETTLE_CYCLES, 4'd4, stopped-cycles before evaluation; MOVE_TIMEOUT, 5'd16, cycles to wait for reel motion.
REQ-002 SHALL have ports, clock and reset first: clk in 1 reel-tick clock; rst in 1 sync reset; start in 1 one-cycle spin request; a_v_count in 10 reel A offset, 0..239; b_v_count in 10 reel B offset; c_v_count in 10 reel C offset; reel_moving in 3 per-reel nonzero-speed flags, bit0=A; spin_accept out 1 one-cycle charge pulse; busy out 1 spin in progress; result_valid out 1 one-cycle result pulse; symbol_a/symbol_b/symbol_c out 2 each, payline symbols; win_code out 2, 0 none, 1 pair, 2 triple; credits out 8 credit balance; jackpot out 1 jackpot flag.
REQ-003 SHALL use reset rst, synchronous, active-high; clock clk.

Function
REQ-004 SHALL implement FSM IDLE, WAIT_MOVE, SPIN, SETTLE, EVAL, with busy=1 in every state except IDLE.
REQ-005 IDLE: start=1 and credits>=SPIN_COST SHALL deduct SPIN_COST, pulse spin_accept, and enter WAIT_MOVE on the next edge.
REQ-006 IDLE: start=1 with credits<SPIN_COST SHALL be ignored, with no pulse and no credit change.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 WAIT_MOVE: reel_moving!=0 SHALL enter SPIN.
REQ-009 WAIT_MOVE: after MOVE_TIMEOUT consecutive cycles with reel_moving==0, the block SHALL refund SPIN_COST (saturating at 255), return to IDLE, and not pulse result_valid.
REQ-010 SPIN: reel_moving==0 SHALL enter SETTLE with the settle counter cleared.
REQ-011 SETTLE: the settle counter SHALL increment each cycle while reel_moving==0, and any nonzero reel_moving SHALL return the FSM to SPIN.
REQ-012 SETTLE: when the counter reaches SETTLE_CYCLES-1, the FSM SHALL enter EVAL.
REQ-013 EVAL SHALL last exactly one cycle, then return to IDLE, with result_valid=1 during the IDLE entry cycle.
REQ-014 EVAL SHALL compute the symbol for each reel as row=(v_count+PAYLINE_OFFSET) mod 240 and symbol=row/60, using a compare chain with no divider; v_count>=240 SHALL be treated as v_count-240.
REQ-015 EVAL SHALL register symbol_a/b/c and hold them until the next EVAL.
REQ-016 win_code SHALL be 2 if all three symbols are equal, 1 if exactly two are equal, and 0 otherwise.
REQ-017 the payout SHALL be TRIPLE_PAY, PAIR_PAY, or 0 respectively, added to credits during EVAL and saturating at 8'd255.
REQ-018 win_code SHALL be held until the next spin_accept, which clears it to 0.
REQ-019 a start that coincides with the result_valid cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-020 the arithmetic SHALL use 9-bit intermediates for the credit add and the row sum, with no wrap-around of credits.

Reset
REQ-021 rst SHALL force the IDLE state, credits=CREDIT_INIT, symbols=0, win_code=0, jackpot=0, spin_accept=0, result_valid=0, busy=0, and clear both counters.
REQ-022 rst asserted mid-spin SHALL abort the spin without refund or payout, and no result_valid SHALL follow.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 with JACKPOT_STREAK_EN defined, a triple of symbol 2'd3 SHALL pay TRIPLE_PAY*4 (saturating) and set jackpot=1 until the next spin_accept.
REQ-025 without JACKPOT_STREAK_EN, jackpot SHALL be constant 0 and a symbol-3 triple SHALL pay TRIPLE_PAY.

Verification
REQ-026 the bench SHALL apply reset then start, with reel_moving=3'b111 for 50 cycles then 0, and v_counts 0/0/0 -> spin_accept at cycle 1, credits 19, result_valid 5 cycles after stop, symbols 0/0/0, win_code 2, credits 29.
REQ-027 the bench SHALL apply v_counts 10/100/200 with offset 30 (rows 40/130/230) -> symbols 0/2/3, win_code 0, credits 19.
REQ-028 the bench SHALL apply start with reel_moving held 0 -> spin_accept, and after 16 cycles credits restored to 20, IDLE, no result_valid.
REQ-029 the bench SHALL apply 20 losing spins then start -> 21st start ignored, credits 0, busy stays 0.
REQ-030 the bench SHALL drop reel_moving to 0 for 2 cycles then raise bit1 during SETTLE -> return to SPIN, no evaluation until a full 4 stopped cycles.
REQ-031 the bench SHALL assert rst mid-SPIN with credits 19 -> credits 20, IDLE next cycle, no result_valid; and with JACKPOT_STREAK_EN, v_counts 200/200/200 (rows 230) -> symbols 3/3/3, payout 40, jackpot=1.
